// File: rtl/regs_wb_ctrl_if.sv
// Write-back controller bus: EX results, long-latency issue/result handshake,
// register-file write port and the busy scoreboard.
interface regs_wb_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ex_valid_i;
    logic [4:0]      ex_waddr_i;
    logic [XLEN-1:0] ex_wdata_i;
    logic            lsu_issue_i;
    logic [4:0]      lsu_issue_rd_i;
    logic            lsu_valid_i;
    logic [4:0]      lsu_waddr_i;
    logic [XLEN-1:0] lsu_wdata_i;
    logic            lsu_ready_o;
    logic [4:0]      reg_waddr_o;
    logic [XLEN-1:0] reg_wdata_o;
    logic            reg_wen_o;
    logic [31:0]     busy_o;

    // Pipeline side: produces results and issues long-latency ops.
    modport master (
        output ex_valid_i, ex_waddr_i, ex_wdata_i,
        output lsu_issue_i, lsu_issue_rd_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  lsu_ready_o, reg_waddr_o, reg_wdata_o, reg_wen_o, busy_o
    );

    // Controller side.
    modport slave (
        input  ex_valid_i, ex_waddr_i, ex_wdata_i,
        input  lsu_issue_i, lsu_issue_rd_i,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output lsu_ready_o, reg_waddr_o, reg_wdata_o, reg_wen_o, busy_o
    );
endinterface

// File: rtl/regs_wb_ctrl.sv
// Write-back controller: arbitrates the single register-file write port between
// EX results (highest priority) and late results buffered in a small FIFO,
// and keeps a busy scoreboard of in-flight long-latency destinations.
module regs_wb_ctrl #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    regs_wb_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [XLEN-1:0]  fifo_data [FIFO_DEPTH];
    logic [4:0]       fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             fifo_empty;
    logic             xfer;
    logic             sel_ex;
    logic             sel_pop;
    logic             sel_byp;
    logic             sel_any;
    logic             push;
    logic             pop;
    logic [4:0]       sel_waddr;
    logic [XLEN-1:0]  sel_wdata;

    logic [31:0]      busy_q;
    logic [31:0]      busy_set;
    logic [31:0]      busy_clr;
    logic [31:0]      busy_next;

    logic [4:0]       reg_waddr_q;
    logic [XLEN-1:0]  reg_wdata_q;
    logic             reg_wen_q;

    assign fifo_empty      = (count == '0);
    assign bus.lsu_ready_o = !rst && (count < DEPTH_C);
    assign xfer            = bus.lsu_valid_i && bus.lsu_ready_o;

    // Pick the write-port source: EX first, then the FIFO head, then a bypassed late result.
    always_comb begin
        sel_ex    = bus.ex_valid_i;
        sel_pop   = !bus.ex_valid_i && !fifo_empty;
        sel_byp   = !bus.ex_valid_i && fifo_empty && xfer;
        sel_any   = sel_ex || sel_pop || sel_byp;
        sel_waddr = '0;
        sel_wdata = '0;
        if (sel_ex) begin
            sel_waddr = bus.ex_waddr_i;
            sel_wdata = bus.ex_wdata_i;
        end else if (sel_pop) begin
            sel_waddr = fifo_addr[rd_ptr];
            sel_wdata = fifo_data[rd_ptr];
        end else if (sel_byp) begin
            sel_waddr = bus.lsu_waddr_i;
            sel_wdata = bus.lsu_wdata_i;
        end
        push = xfer && !sel_byp;
        pop  = sel_pop;
    end

    // Scoreboard update: a late result retiring clears its bit, a new issue sets it (set wins).
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (bus.lsu_issue_i && (bus.lsu_issue_rd_i != 5'd0)) begin
            busy_set = 32'd1 << bus.lsu_issue_rd_i;
        end
        if (sel_pop || sel_byp) begin
            busy_clr = 32'd1 << sel_waddr;
        end
        busy_next = ((busy_q & ~busy_clr) | busy_set) & ~32'd1;
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_data[wr_ptr] <= bus.lsu_wdata_i;
            fifo_addr[wr_ptr] <= bus.lsu_waddr_i;
        end
    end

    // Pointers, occupancy, scoreboard and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            busy_q      <= '0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            reg_wen_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            busy_q      <= busy_next;
            reg_waddr_q <= sel_waddr;
            reg_wdata_q <= sel_wdata;
            reg_wen_q   <= sel_any && (sel_waddr != 5'd0);
        end
    end

    assign bus.reg_waddr_o = reg_waddr_q;
    assign bus.reg_wdata_o = reg_wdata_q;
    assign bus.reg_wen_o   = reg_wen_q;
    assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_regs_wb_ctrl.sv
// Directed testbench for the write-back controller: reset, EX path, bypass with
// scoreboard, EX/LSU conflict, FIFO full and pointer wrap, x0 handling, mid-op reset.
module tb_regs_wb_ctrl;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    regs_wb_ctrl_if #(.XLEN(32)) bus ();

    regs_wb_ctrl #(.XLEN(32), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Set every input of the controller, then let combinational paths settle.
    task automatic applyStimulus(input logic ex_v, input logic [4:0] ex_a, input logic [31:0] ex_d,
                                 input logic iss, input logic [4:0] iss_rd,
                                 input logic lv, input logic [4:0] la, input logic [31:0] ld);
        bus.ex_valid_i     = ex_v;
        bus.ex_waddr_i     = ex_a;
        bus.ex_wdata_i     = ex_d;
        bus.lsu_issue_i    = iss;
        bus.lsu_issue_rd_i = iss_rd;
        bus.lsu_valid_i    = lv;
        bus.lsu_waddr_i    = la;
        bus.lsu_wdata_i    = ld;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkWrite(input string tag, input logic wen, input logic [4:0] a, input logic [31:0] d);
        checkOutput({tag, ".wen"}, 32'(bus.reg_wen_o), 32'(wen));
        checkOutput({tag, ".waddr"}, 32'(bus.reg_waddr_o), 32'(a));
        checkOutput({tag, ".wdata"}, bus.reg_wdata_o, d);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        $display("[TB] start");

        // Reset held two cycles with a late result offered.
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h33);
        stepClock();
        stepClock();
        checkOutput("rst.wen", 32'(bus.reg_wen_o), 32'd0);
        checkOutput("rst.busy", bus.busy_o, 32'h0);
        checkOutput("rst.ready", 32'(bus.lsu_ready_o), 32'd0);
        rst = 1'b0;
        idle();
        checkOutput("rel.ready", 32'(bus.lsu_ready_o), 32'd1);
        stepClock();
        checkOutput("rel.nowrite", 32'(bus.reg_wen_o), 32'd0);

        // EX path: one-cycle write pulse.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        stepClock();
        checkWrite("ex", 1'b1, 5'd5, 32'hDEADBEEF);
        idle();
        stepClock();
        checkOutput("ex.pulse", 32'(bus.reg_wen_o), 32'd0);

        // Issue x7, then bypass its result; busy drops with the write.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
        stepClock();
        checkOutput("iss.busy", bus.busy_o, 32'h0000_0080);
        idle();
        stepClock();
        stepClock();
        checkOutput("iss.hold", bus.busy_o, 32'h0000_0080);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h1234);
        stepClock();
        checkWrite("byp", 1'b1, 5'd7, 32'h1234);
        checkOutput("byp.busy", bus.busy_o, 32'h0);

        // EX and LSU together: LSU result goes through the FIFO one cycle later.
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 1'b1, 5'd2, 32'h22);
        stepClock();
        checkWrite("cf.ex", 1'b1, 5'd1, 32'h11);
        checkOutput("cf.busy", bus.busy_o, 32'h0000_0004);
        idle();
        stepClock();
        checkWrite("cf.lsu", 1'b1, 5'd2, 32'h22);
        checkOutput("cf.clr", bus.busy_o, 32'h0);
        stepClock();
        checkOutput("cf.idle", 32'(bus.reg_wen_o), 32'd0);

        // Set and clear of the same register in one cycle: set wins.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99);
        stepClock();
        checkWrite("sw", 1'b1, 5'd9, 32'h99);
        checkOutput("sw.busy", bus.busy_o, 32'h0000_0200);

        // Fill the FIFO twice behind continuous EX writes; drain in order (pointers wrap).
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                applyStimulus(1'b1, 5'd3, 32'h300 + 32'(i), 1'b0, 5'd0,
                              1'b1, 5'(10 + 10 * r + i), 32'hA0 + 32'(16 * r + i));
                checkOutput("fill.ready", 32'(bus.lsu_ready_o), 32'd1);
                stepClock();
                checkWrite("fill.ex", 1'b1, 5'd3, 32'h300 + 32'(i));
            end
            applyStimulus(1'b1, 5'd3, 32'h3FF, 1'b0, 5'd0, 1'b1, 5'd31, 32'hFF);
            checkOutput("full.ready", 32'(bus.lsu_ready_o), 32'd0);
            stepClock();
            checkWrite("full.ex", 1'b1, 5'd3, 32'h3FF);
            idle();
            for (int i = 0; i < 4; i++) begin
                stepClock();
                checkWrite("drain", 1'b1, 5'(10 + 10 * r + i), 32'hA0 + 32'(16 * r + i));
            end
            stepClock();
            checkOutput("drain.end", 32'(bus.reg_wen_o), 32'd0);
            checkOutput("drain.ready", 32'(bus.lsu_ready_o), 32'd1);
        end

        // x0 via bypass: no write enable, address/data still carried.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h55);
        stepClock();
        checkWrite("x0.byp", 1'b0, 5'd0, 32'h55);

        // x0 via FIFO: entry must be consumed, so the next late result bypasses.
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b1, 5'd0, 32'h66);
        stepClock();
        checkWrite("x0.ex", 1'b1, 5'd4, 32'h44);
        idle();
        stepClock();
        checkWrite("x0.pop", 1'b0, 5'd0, 32'h66);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd8, 32'h88);
        stepClock();
        checkWrite("x0.after", 1'b1, 5'd8, 32'h88);

        // Mid-operation reset with three buffered entries and x15 busy.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd3, 32'h500 + 32'(i), (i == 0), 5'd15,
                          1'b1, 5'(16 + i), 32'hC0 + 32'(i));
            stepClock();
        end
        checkOutput("mid.busy", bus.busy_o, 32'h0000_8200);
        rst = 1'b1;
        idle();
        stepClock();
        checkOutput("mid.rst.wen", 32'(bus.reg_wen_o), 32'd0);
        checkOutput("mid.rst.busy", bus.busy_o, 32'h0);
        checkOutput("mid.rst.ready", 32'(bus.lsu_ready_o), 32'd0);
        rst = 1'b0;
        idle();
        stepClock();
        checkOutput("mid.nowrite1", 32'(bus.reg_wen_o), 32'd0);
        stepClock();
        checkOutput("mid.nowrite2", 32'(bus.reg_wen_o), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd21, 32'h77);
        stepClock();
        checkWrite("mid.empty", 1'b1, 5'd21, 32'h77);
        idle();
        stepClock();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
